multdiv_issue_ctrl: RTL and testbench

Sits between the execute stage and the multiplier/divider units. It captures operands and the destination register when a mul/div instruction issues, and holds the operands stable. It launches a one-cycle ctrl_MULT or ctrl_DIV start pulse and stalls the pipeline while the unit iterates. When the unit raises data_resultRDY, it produces a single-cycle register-file writeback: either the product/quotient, or an rstatus exception code.

---
 rtl/multdiv_issue_ctrl_pkg.sv | 26 ++
 rtl/multdiv_timeout_counter.sv | 40 ++++
 rtl/multdiv_issue_ctrl.sv | 176 +++++++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared definitions for the mul/div issue controller and the pipeline bypass logic.
package multdiv_issue_ctrl_pkg;

  // Controller state encoding; values are fixed so other blocks can decode them directly.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StWb    = 2'd3
  } md_state_e;

  // Default datapath width and timeout budget.
  localparam int unsigned DefaultWidth   = 32;
  localparam int unsigned DefaultTimeout = 40;

  // Register that receives the exception code, and the codes themselves.
  localparam int unsigned RstatusReg  = 30;
  localparam int unsigned MultExcCode = 4;
  localparam int unsigned DivExcCode  = 5;

  // Width of a counter that must reach (cycles - 1) with headroom.
  function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/multdiv_timeout_counter.sv
// Cycle counter bounding how long the controller waits for a unit result.
module multdiv_timeout_counter
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeout
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned CntW = timeout_cnt_width(TIMEOUT_CYCLES);

  logic [CntW-1:0] count_q, count_d;

  // Next count: clear has priority; otherwise hold unless enabled.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Last permitted wait cycle.
  assign terminal = (count_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the multiplier/divider: captures operands, pulses the unit start,
// stalls the pipeline while the unit iterates and produces a single-cycle writeback.
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH          = DefaultWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeout,
  parameter int unsigned RSTATUS_REG    = RstatusReg,
  parameter int unsigned MULT_EXC_CODE  = MultExcCode,
  parameter int unsigned DIV_EXC_CODE   = DivExcCode
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_mult,
  input  logic             issue_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       dest_reg,
  output logic [WIDTH-1:0] data_operandA,
  output logic [WIDTH-1:0] data_operandB,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  input  logic [WIDTH-1:0] mult_result,
  input  logic             mult_exception,
  input  logic             mult_resultRDY,
  input  logic [WIDTH-1:0] div_result,
  input  logic             div_exception,
  input  logic             div_resultRDY,
  output logic             stall,
  output logic             wb_valid,
  output logic [4:0]       wb_reg,
  output logic [WIDTH-1:0] wb_data
);

  md_state_e        state_q, state_d;
  logic             op_mult_q, op_mult_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [4:0]       dest_q, dest_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_reg_q, wb_reg_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;

  logic             issue_any;
  logic             sel_rdy;
  logic             sel_exc;
  logic [WIDTH-1:0] sel_result;
  logic [WIDTH-1:0] exc_code;
  logic             finish;
  logic             finish_exc;
  logic             cnt_clear;
  logic             cnt_enable;
  logic             cnt_terminal;

  assign issue_any = issue_mult | issue_div;

  // Only the unit that was started is observed; the other one may be busy with nothing.
  assign sel_rdy    = op_mult_q ? mult_resultRDY : div_resultRDY;
  assign sel_exc    = op_mult_q ? mult_exception : div_exception;
  assign sel_result = op_mult_q ? mult_result    : div_result;
  assign exc_code   = op_mult_q ? WIDTH'(MULT_EXC_CODE) : WIDTH'(DIV_EXC_CODE);

  multdiv_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (cnt_terminal)
  );

  // FSM next state, operand capture and completion detection.
  always_comb begin
    state_d    = state_q;
    op_mult_d  = op_mult_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    dest_d     = dest_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    finish     = 1'b0;
    finish_exc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (issue_any) begin
          opa_d     = operand_a;
          opb_d     = operand_b;
          dest_d    = dest_reg;
          op_mult_d = issue_mult;  // mult wins when both lines are high
          state_d   = StIssue;
        end
      end
      StIssue: begin
        cnt_clear = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        if (sel_rdy) begin
          finish     = 1'b1;
          finish_exc = sel_exc;
          state_d    = StWb;
        end else if (cnt_terminal) begin
          finish     = 1'b1;
          finish_exc = 1'b1;
          state_d    = StWb;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      StWb: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Writeback contents, loaded on the WAIT->WB transition so they are valid for exactly WB.
  always_comb begin
    wb_valid_d = 1'b0;
    wb_reg_d   = '0;
    wb_data_d  = '0;
    if (finish) begin
      if (finish_exc) begin
        wb_valid_d = 1'b1;
        wb_reg_d   = 5'(RSTATUS_REG);
        wb_data_d  = exc_code;
      end else if (dest_q != 5'd0) begin
        wb_valid_d = 1'b1;
        wb_reg_d   = dest_q;
        wb_data_d  = sel_result;
      end
    end
  end

  // State, operand holds and writeback registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      op_mult_q  <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      dest_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_mult_q  <= op_mult_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      dest_q     <= dest_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign data_operandA = opa_q;
  assign data_operandB = opb_q;
  assign ctrl_MULT     = (state_q == StIssue) &  op_mult_q;
  assign ctrl_DIV      = (state_q == StIssue) & ~op_mult_q;
  // Stall starts in the issue cycle itself and drops in WB so the pipeline resumes there.
  assign stall         = (state_q == StIssue) | (state_q == StWait) |
                         ((state_q == StIdle) & issue_any);
  assign wb_valid      = wb_valid_q;
  assign wb_reg        = wb_reg_q;
  assign wb_data       = wb_data_q;

  // At most one start line per cycle.
  a_start_onehot : assert property (@(posedge clock) disable iff (!reset)
    !(ctrl_MULT && ctrl_DIV));

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench for multdiv_issue_ctrl: table of operations plus a reset-abort sequence.
module tb_multdiv_issue_ctrl;

  localparam int unsigned TO = 40;

  logic        clock;
  logic        reset;
  logic        issue_mult;
  logic        issue_div;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  dest_reg;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] mult_result;
  logic        mult_exception;
  logic        mult_resultRDY;
  logic [31:0] div_result;
  logic        div_exception;
  logic        div_resultRDY;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  multdiv_issue_ctrl #(
    .WIDTH          (32),
    .TIMEOUT_CYCLES (TO),
    .RSTATUS_REG    (30),
    .MULT_EXC_CODE  (4),
    .DIV_EXC_CODE   (5)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .issue_mult     (issue_mult),
    .issue_div      (issue_div),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .dest_reg       (dest_reg),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .mult_result    (mult_result),
    .mult_exception (mult_exception),
    .mult_resultRDY (mult_resultRDY),
    .div_result     (div_result),
    .div_exception  (div_exception),
    .div_resultRDY  (div_resultRDY),
    .stall          (stall),
    .wb_valid       (wb_valid),
    .wb_reg         (wb_reg),
    .wb_data        (wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        m;
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    int          rdy_cyc;   // cycle (issue = 0) at which RDY is driven; 0 means never
    logic        exc;
    logic [31:0] res;
    logic        stale;     // drive the selected RDY during ISSUE
    logic        noise;     // drive issue lines during WAIT
    logic        exp_valid;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cur = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL [vec %0d] %s: got 0x%0h, want 0x%0h", cur, name, act, exp);
  endtask

  task automatic add(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] dest, input int rdy_cyc, input logic exc,
                     input logic [31:0] res, input logic stale, input logic noise,
                     input logic ev, input logic [4:0] er, input logic [31:0] ed);
    vec_t v;
    v.m = m; v.d = d; v.a = a; v.b = b; v.dest = dest; v.rdy_cyc = rdy_cyc; v.exc = exc;
    v.res = res; v.stale = stale; v.noise = noise;
    v.exp_valid = ev; v.exp_reg = er; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  task automatic clear_inputs();
    issue_mult = 1'b0; issue_div = 1'b0;
    operand_a = '0; operand_b = '0; dest_reg = '0;
    mult_result = '0; mult_exception = 1'b0; mult_resultRDY = 1'b0;
    div_result = '0; div_exception = 1'b0; div_resultRDY = 1'b0;
  endtask

  // Sample at the falling edge; any writeback is matched against the scoreboard.
  task automatic half();
    exp_t e;
    @(negedge clock);
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 64'(wb_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        check("wb_reg", 64'(wb_reg), 64'(e.r));
        check("wb_data", 64'(wb_data), 64'(e.d));
      end
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    exp_t e;
    logic is_mult;
    int   wb_cyc;
    v = vecs[idx];
    cur = idx;
    is_mult = v.m;
    wb_cyc = (v.rdy_cyc != 0) ? v.rdy_cyc + 1 : 2 + int'(TO);
    // Cycle 0: issue
    issue_mult = v.m; issue_div = v.d;
    operand_a = v.a; operand_b = v.b; dest_reg = v.dest;
    if (v.exp_valid) begin
      e.r = v.exp_reg; e.d = v.exp_data;
      sb.push_back(e);
    end
    half();
    check("stall_c0", 64'(stall), 64'(1));
    check("ctrl_c0", 64'({ctrl_MULT, ctrl_DIV}), 64'(0));
    adv();
    // Cycle 1: start pulse, operand inputs now garbage
    clear_inputs();
    operand_a = ~v.a; operand_b = ~v.b; dest_reg = ~v.dest;
    if (v.stale) begin
      if (is_mult) begin mult_resultRDY = 1'b1; mult_result = 32'hbad; end
      else begin div_resultRDY = 1'b1; div_result = 32'hbad; end
    end
    half();
    check("ctrl_MULT_c1", 64'(ctrl_MULT), 64'(is_mult));
    check("ctrl_DIV_c1", 64'(ctrl_DIV), 64'(!is_mult));
    check("stall_c1", 64'(stall), 64'(1));
    check("opA_c1", 64'(data_operandA), 64'(v.a));
    check("opB_c1", 64'(data_operandB), 64'(v.b));
    adv();
    // Cycles 2..: wait, writeback, back to idle
    for (int c = 2; c <= wb_cyc + 1; c++) begin
      clear_inputs();
      operand_a = ~v.a; operand_b = ~v.b; dest_reg = ~v.dest;
      if (c < wb_cyc) begin
        // The unselected unit chatters; it must be ignored.
        if (is_mult) begin div_resultRDY = 1'b1; div_exception = 1'b1; div_result = 32'h1111; end
        else begin mult_resultRDY = 1'b1; mult_exception = 1'b1; mult_result = 32'h2222; end
      end
      if (c == v.rdy_cyc || c == wb_cyc) begin
        // At wb_cyc this is a stale RDY during WB.
        if (is_mult) begin
          mult_resultRDY = 1'b1;
          mult_exception = (c == wb_cyc) ? 1'b1 : v.exc;
          mult_result    = (c == wb_cyc) ? 32'h3333 : v.res;
        end else begin
          div_resultRDY = 1'b1;
          div_exception = (c == wb_cyc) ? 1'b1 : v.exc;
          div_result    = (c == wb_cyc) ? 32'h4444 : v.res;
        end
      end
      if (v.noise && c == 5) begin
        issue_div = 1'b1; operand_a = 32'h5555;
      end
      half();
      check($sformatf("stall_c%0d", c), 64'(stall), 64'(c < wb_cyc));
      check($sformatf("wb_valid_c%0d", c), 64'(wb_valid), 64'(c == wb_cyc && v.exp_valid));
      check($sformatf("ctrl_c%0d", c), 64'({ctrl_MULT, ctrl_DIV}), 64'(0));
      check($sformatf("opA_c%0d", c), 64'(data_operandA), 64'(v.a));
      adv();
    end
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Table: m, d, a, b, dest, rdy_cyc, exc, res, stale, noise, exp_valid, exp_reg, exp_data
    add(1'b1, 1'b0, 32'd3,   32'd5,   5'd7,  19, 1'b0, 32'd15,    1'b0, 1'b0, 1'b1, 5'd7,  32'd15);
    add(1'b1, 1'b0, 32'd100, 32'd200, 5'd9,  10, 1'b1, 32'd20000, 1'b0, 1'b0, 1'b1, 5'd30, 32'd4);
    add(1'b0, 1'b1, 32'd7,   32'd0,   5'd3,  25, 1'b1, 32'hdead,  1'b0, 1'b0, 1'b1, 5'd30, 32'd5);
    add(1'b1, 1'b0, 32'd11,  32'd12,  5'd0,  8,  1'b0, 32'd132,   1'b0, 1'b0, 1'b0, 5'd0,  32'd0);
    add(1'b0, 1'b1, 32'd50,  32'd5,   5'd4,  0,  1'b0, 32'd0,     1'b0, 1'b0, 1'b1, 5'd30, 32'd5);
    add(1'b1, 1'b1, 32'd6,   32'd7,   5'd12, 6,  1'b0, 32'd42,    1'b0, 1'b0, 1'b1, 5'd12, 32'd42);
    add(1'b0, 1'b1, 32'd100, 32'd7,   5'd31, 12, 1'b0, 32'd14,    1'b0, 1'b1, 1'b1, 5'd31, 32'd14);
    add(1'b1, 1'b0, 32'd9,   32'd9,   5'd2,  5,  1'b0, 32'd81,    1'b1, 1'b0, 1'b1, 5'd2,  32'd81);
    add(1'b1, 1'b0, 32'd1,   32'd1,   5'd6,  0,  1'b0, 32'd0,     1'b0, 1'b0, 1'b1, 5'd30, 32'd4);

    reset = 1'b1;
    clear_inputs();
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    half();
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_ctrl", 64'({ctrl_MULT, ctrl_DIV}), 64'(0));
    check("rst_opA", 64'(data_operandA), 64'(0));
    check("rst_opB", 64'(data_operandB), 64'(0));
    check("rst_wb_valid", 64'(wb_valid), 64'(0));
    check("rst_wb_reg", 64'(wb_reg), 64'(0));
    check("rst_wb_data", 64'(wb_data), 64'(0));
    adv();
    reset = 1'b1;
    adv();

    foreach (vecs[i]) run_vec(i);

    // Reset asserted during WAIT aborts the op.
    cur = 100;
    issue_mult = 1'b1; operand_a = 32'd21; operand_b = 32'd2; dest_reg = 5'd5;
    half();
    adv();
    clear_inputs();
    repeat (3) begin
      half();
      adv();
    end
    check("pre_rst_stall", 64'(stall), 64'(1));
    reset = 1'b0;
    #1;
    check("abort_stall", 64'(stall), 64'(0));
    check("abort_ctrl", 64'({ctrl_MULT, ctrl_DIV}), 64'(0));
    check("abort_opA", 64'(data_operandA), 64'(0));
    check("abort_opB", 64'(data_operandB), 64'(0));
    check("abort_wb_valid", 64'(wb_valid), 64'(0));
    check("abort_wb_reg", 64'(wb_reg), 64'(0));
    check("abort_wb_data", 64'(wb_data), 64'(0));
    adv();
    reset = 1'b1;
    adv();
    for (int k = 0; k < int'(TO) + 5; k++) begin
      mult_resultRDY = 1'b1; mult_result = 32'd42;
      half();
      check("abort_no_wb", 64'(wb_valid), 64'(0));
      check("abort_no_stall", 64'(stall), 64'(0));
      check("abort_no_ctrl", 64'(ctrl_MULT), 64'(0));
      adv();
    end
    clear_inputs();

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
